ibi_byte_tx: RTL and testbench
==============================

// Module: ibi_byte_tx
// PURPOSE
// - Target-side IBI payload transmitter, directly downstream of the IBI descriptor stage. Consumes its MDB+data byte stream
//   (valid/ready/last) and shifts it MSB-first onto SDA on controller-driven SCL edges, one T-bit per byte (I3C SDR read).
// - Reports completion, controller early-termination and upstream underrun back to the byte source and the target FSM.
// PARAMETERS
// - IbiFifoWidth  8  byte stream width; only 8 is legal (elaboration-time assertion otherwise)
// PORTS
// - clk_i           in   1  core clock; single clock domain
// - rst_i           in   1  reset; synchronous, active-high
// - start_i         in   1  pulse: IBI address ACKed; payload phase begins
// - abort_i         in   1  bus Sr/P detected; terminate immediately
// - scl_negedge_i   in   1  one-cycle strobe, SCL falling edge (synchronised)
// - scl_posedge_i   in   1  one-cycle strobe, SCL rising edge (synchronised)
// - sda_i           in   1  synchronised SDA level
// - sda_o           out  1  SDA drive value
// - sda_oe_o        out  1  1 = push-pull drive sda_o; 0 = released (high-Z, pull-up)
// - byte_valid_i    in   1  upstream byte valid
// - byte_ready_o    out  1  byte accepted when valid&ready
// - byte_i          in   8  byte (first byte after start_i is MDB)
// - byte_last_i     in   1  byte is final payload byte
// - byte_err_o      out  1  pulse: controller abort or underrun
// - done_o          out  1  pulse: last byte + T-bit sent normally
// - busy_o          out  1  state != Idle
// - bytes_sent_o    out  8  bytes completed this IBI, saturates at 8'hFF, cleared on start_i
// BEHAVIOUR
// - Reset: all outputs 0, sda_o=1, state Idle. rst_i mid-transfer wins over every other input; SDA released same cycle.
// - FSM states: Idle, Load, Shift, TDrive, TRelease.
//   Idle:     start_i -> Load; bytes_sent_o<=0. start_i while busy ignored.
//   Load:     byte_ready_o=1; on valid: shreg<=byte_i, last_q<=byte_last_i, bit_cnt<=7 -> Shift.
//             scl_negedge_i while still Load (no byte) = underrun: byte_err_o, release SDA -> Idle.
//   Shift:    on each scl_negedge_i drive sda_o=shreg[bit_cnt], sda_oe_o=1; after bit 0 is presented,
//             next scl_negedge_i -> TDrive.
//   TDrive:   drive sda_o=~last_q (1 = more data, 0 = end), oe=1; bytes_sent_o++ (sat).
//             If !last_q, byte_ready_o=1 here (prefetch into next_q buffer, 1 entry).
//             scl_posedge_i: last_q ? (release, done_o pulse -> Idle) : (release -> TRelease).
//   TRelease: SDA released so controller may pull low. On scl_negedge_i: sample sda_i.
//             sda_i==0 -> byte_err_o, Idle (prefetched byte dropped, never re-requested).
//             sda_i==1 -> prefetched byte present: load shreg, drive its bit 7 this edge, bit_cnt<=6 -> Shift;
//             no byte -> underrun (byte_err_o, Idle).
// - First bit (MDB bit 7) is driven on the first scl_negedge_i after entering Load with a byte held.
// - Handshake: ready never depends combinationally on valid; at most one byte held beyond shreg; byte_ready_o=0 in Idle/Shift.
// - abort_i in any non-Idle state: release SDA, ready 0, byte_err_o pulse only if a byte was outstanding, -> Idle next cycle.
// - Simultaneous scl_negedge_i and scl_posedge_i: illegal; assertion.
// - Simultaneous abort_i and scl edge: abort wins.
// - Latency: sda_o updates in the cycle after the strobe (registered outputs).
// STRUCTURE
// - Single module, no sub-module; ~180 lines.
// - Shared package i3c_pkg: T_BIT_MORE=1'b1 / T_BIT_END=1'b0 constants, and the ibi_tx_state_e typedef
//   (the target FSM decodes busy/state for debug).
// - Local: 8-bit shreg, 3-bit bit_cnt, 8-bit next_q + valid flag, last_q.
// TESTING
// - MDB only: start, byte 8'hA5 last=1 -> SDA 1,0,1,0,0,1,0,1 then T=0; done_o once; bytes_sent_o=1.
// - MDB 8'h1F + data 8'h00,8'hFF (last) -> T=1,1,0; 27 negedges total; done_o once; bytes_sent_o=3.
// - Controller abort: 3-byte IBI, sda_i forced 0 in TRelease after byte 1 -> byte_err_o, Idle, no 3rd ready.
// - Underrun: MDB last=0, next byte withheld past TRelease negedge -> byte_err_o, SDA released, Idle.
// - abort_i mid-bit 4 of byte 2 -> sda_oe_o=0 next cycle, Idle, ready stays 0; new start_i works normally.
// - rst_i during TDrive -> all outputs reset values next cycle; bytes_sent_o=0.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared I3C target definitions: T-bit encodings and IBI transmitter state type.
package i3c_pkg;

    localparam logic T_BIT_MORE = 1'b1;
    localparam logic T_BIT_END  = 1'b0;

    localparam int unsigned IBI_BIT_CNT_W = 3;
    localparam int unsigned IBI_CNT_W     = 8;

    typedef enum logic [2:0] {
        IBI_TX_IDLE     = 3'd0,
        IBI_TX_LOAD     = 3'd1,
        IBI_TX_SHIFT    = 3'd2,
        IBI_TX_TDRIVE   = 3'd3,
        IBI_TX_TRELEASE = 3'd4
    } ibi_tx_state_e;

endpackage

// File: rtl/ibi_byte_tx.sv
// IBI payload transmitter: shifts the MDB + data bytes MSB-first onto SDA on
// controller SCL edges, appending a T-bit per byte, with a one-entry prefetch.
module ibi_byte_tx
    import i3c_pkg::*;
#(
    parameter int unsigned IbiFifoWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    scl_negedge_i,
    input  logic                    scl_posedge_i,
    input  logic                    sda_i,
    output logic                    sda_o,
    output logic                    sda_oe_o,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    input  logic [IbiFifoWidth-1:0] byte_i,
    input  logic                    byte_last_i,
    output logic                    byte_err_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic [IBI_CNT_W-1:0]    bytes_sent_o
);

    if (IbiFifoWidth != 8) begin : g_bad_width
        $error("ibi_byte_tx: IbiFifoWidth must be 8");
    end

    localparam int unsigned MsbIdx = IbiFifoWidth - 1;

    ibi_tx_state_e             state_q, state_d;
    logic [IbiFifoWidth-1:0]   shreg_q, shreg_d;
    logic [IBI_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                      bits_done_q, bits_done_d;
    logic                      last_q, last_d;
    logic [IbiFifoWidth-1:0]   next_q, next_d;
    logic                      next_last_q, next_last_d;
    logic                      next_vld_q, next_vld_d;
    logic                      sda_q, sda_d;
    logic                      oe_q, oe_d;
    logic                      ready_q, ready_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic [IBI_CNT_W-1:0]      bytes_q, bytes_d;

    logic accept;
    logic outstanding;

    assign accept      = byte_valid_i & ready_q;
    // A byte counts as outstanding while it sits in shreg unfinished or in the prefetch slot.
    assign outstanding = (state_q == IBI_TX_SHIFT) || (state_q == IBI_TX_TDRIVE) ||
                         next_vld_q || accept;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        bits_done_d = bits_done_q;
        last_d      = last_q;
        next_d      = next_q;
        next_last_d = next_last_q;
        next_vld_d  = next_vld_q;
        sda_d       = sda_q;
        oe_d        = oe_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        bytes_d     = bytes_q;

        unique case (state_q)
            IBI_TX_IDLE: begin
                sda_d = 1'b1;
                oe_d  = 1'b0;
                if (start_i) begin
                    state_d    = IBI_TX_LOAD;
                    bytes_d    = '0;
                    next_vld_d = 1'b0;
                end
            end

            IBI_TX_LOAD: begin
                if (accept) begin
                    shreg_d     = byte_i;
                    last_d      = byte_last_i;
                    bits_done_d = 1'b0;
                    state_d     = IBI_TX_SHIFT;
                    if (scl_negedge_i) begin
                        sda_d     = byte_i[MsbIdx];
                        oe_d      = 1'b1;
                        bit_cnt_d = IBI_BIT_CNT_W'(6);
                    end else begin
                        bit_cnt_d = IBI_BIT_CNT_W'(7);
                    end
                end else if (scl_negedge_i) begin
                    err_d   = 1'b1;
                    sda_d   = 1'b1;
                    oe_d    = 1'b0;
                    state_d = IBI_TX_IDLE;
                end
            end

            IBI_TX_SHIFT: begin
                if (scl_negedge_i) begin
                    oe_d = 1'b1;
                    if (bits_done_q) begin
                        sda_d       = last_q ? T_BIT_END : T_BIT_MORE;
                        bits_done_d = 1'b0;
                        state_d     = IBI_TX_TDRIVE;
                        if (bytes_q != '1) begin
                            bytes_d = bytes_q + IBI_CNT_W'(1);
                        end
                    end else begin
                        sda_d = shreg_q[bit_cnt_q];
                        if (bit_cnt_q == '0) begin
                            bits_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - IBI_BIT_CNT_W'(1);
                        end
                    end
                end
            end

            IBI_TX_TDRIVE: begin
                if (accept) begin
                    next_d      = byte_i;
                    next_last_d = byte_last_i;
                    next_vld_d  = 1'b1;
                end
                if (scl_posedge_i) begin
                    sda_d = 1'b1;
                    oe_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = IBI_TX_IDLE;
                    end else begin
                        state_d = IBI_TX_TRELEASE;
                    end
                end
            end

            IBI_TX_TRELEASE: begin
                if (scl_negedge_i) begin
                    if (sda_i && next_vld_q) begin
                        shreg_d     = next_q;
                        last_d      = next_last_q;
                        next_vld_d  = 1'b0;
                        sda_d       = next_q[MsbIdx];
                        oe_d        = 1'b1;
                        bit_cnt_d   = IBI_BIT_CNT_W'(6);
                        bits_done_d = 1'b0;
                        state_d     = IBI_TX_SHIFT;
                    end else begin
                        // Controller termination (sda_i low) or nothing prefetched.
                        err_d      = 1'b1;
                        next_vld_d = 1'b0;
                        state_d    = IBI_TX_IDLE;
                    end
                end
            end

            default: begin
                state_d = IBI_TX_IDLE;
                sda_d   = 1'b1;
                oe_d    = 1'b0;
            end
        endcase

        // Bus Sr/P overrides any SCL activity in the same cycle.
        if (abort_i && (state_q != IBI_TX_IDLE)) begin
            state_d     = IBI_TX_IDLE;
            sda_d       = 1'b1;
            oe_d        = 1'b0;
            next_vld_d  = 1'b0;
            bits_done_d = 1'b0;
            bytes_d     = bytes_q;
            done_d      = 1'b0;
            err_d       = outstanding;
        end

        ready_d = (state_d == IBI_TX_LOAD) ||
                  ((state_d == IBI_TX_TDRIVE) && !last_d && !next_vld_d);
        busy_d  = (state_d != IBI_TX_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IBI_TX_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            bits_done_q <= 1'b0;
            last_q      <= 1'b0;
            next_q      <= '0;
            next_last_q <= 1'b0;
            next_vld_q  <= 1'b0;
            sda_q       <= 1'b1;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bytes_q     <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            bits_done_q <= bits_done_d;
            last_q      <= last_d;
            next_q      <= next_d;
            next_last_q <= next_last_d;
            next_vld_q  <= next_vld_d;
            sda_q       <= sda_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            bytes_q     <= bytes_d;
        end
    end

    // The synchroniser upstream never produces both SCL edges in one cycle.
    a_scl_edges_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(scl_negedge_i && scl_posedge_i));

    assign sda_o        = sda_q;
    assign sda_oe_o     = oe_q;
    assign byte_ready_o = ready_q;
    assign byte_err_o   = err_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign bytes_sent_o = bytes_q;

endmodule

// File: tb/tb_ibi_byte_tx.sv
// Scoreboard bench for ibi_byte_tx: expected SDA bits are queued as bytes are
// offered; a monitor pops and compares on every controller SCL rising strobe.
module tb_ibi_byte_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic       scl_negedge_i;
    logic       scl_posedge_i;
    logic       sda_i;
    logic       sda_o;
    logic       sda_oe_o;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic [7:0] byte_i;
    logic       byte_last_i;
    logic       byte_err_o;
    logic       done_o;
    logic       busy_o;
    logic [7:0] bytes_sent_o;

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int ready_cyc = 0;
    int accepted  = 0;

    logic [8:0] src_q[$];
    logic       exp_bits[$];

    always #5 clk_i = ~clk_i;

    ibi_byte_tx #(.IbiFifoWidth(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .scl_negedge_i (scl_negedge_i),
        .scl_posedge_i (scl_posedge_i),
        .sda_i         (sda_i),
        .sda_o         (sda_o),
        .sda_oe_o      (sda_oe_o),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .byte_i        (byte_i),
        .byte_last_i   (byte_last_i),
        .byte_err_o    (byte_err_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .bytes_sent_o  (bytes_sent_o)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) exp_bits.push_back(b[i]);
    endfunction

    function automatic void push_t(input logic last);
        exp_bits.push_back(last ? 1'b0 : 1'b1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic scl_fall();
        idle(3);
        scl_negedge_i = 1'b1;
        idle(1);
        scl_negedge_i = 1'b0;
    endtask

    task automatic scl_rise();
        idle(3);
        scl_posedge_i = 1'b1;
        idle(1);
        scl_posedge_i = 1'b0;
    endtask

    task automatic scl_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            scl_fall();
            scl_rise();
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        idle(1);
        start_i = 1'b0;
    endtask

    // Upstream byte source: presents the queue head, pops on handshake.
    initial begin
        logic hs;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        byte_last_i  = 1'b0;
        forever begin
            @(negedge clk_i);
            hs = byte_valid_i && byte_ready_o;
            @(posedge clk_i);
            #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                accepted++;
            end
            if (src_q.size() > 0) begin
                byte_valid_i = 1'b1;
                {byte_last_i, byte_i} = src_q[0];
            end else begin
                byte_valid_i = 1'b0;
            end
        end
    end

    // Monitor: controller samples SDA on each rising strobe while the target drives.
    initial begin
        logic e;
        forever begin
            @(negedge clk_i);
            if (done_o)       done_cnt++;
            if (byte_err_o)   err_cnt++;
            if (byte_ready_o) ready_cyc++;
            if (scl_posedge_i && sda_oe_o) begin
                total++;
                if (exp_bits.size() == 0) begin
                    bad++;
                    $display("FAIL sda_unexpected: got %0b expected no drive", sda_o);
                end else begin
                    e = exp_bits.pop_front();
                    if (sda_o !== e) begin
                        bad++;
                        $display("FAIL sda_bit: got %0b expected %0b", sda_o, e);
                    end
                end
            end
        end
    end

    initial begin
        int d0, e0, r0, a0;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        scl_negedge_i = 1'b0; scl_posedge_i = 1'b0; sda_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        idle(1);

        check("rst_sda", int'(sda_o), 1);
        check("rst_oe", int'(sda_oe_o), 0);
        check("rst_ready", int'(byte_ready_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_bytes", int'(bytes_sent_o), 0);
        check("rst_err_done", int'({byte_err_o, done_o}), 0);

        // MDB only
        d0 = done_cnt; e0 = err_cnt;
        src_q.push_back({1'b1, 8'hA5});
        push_bits(8'hA5, 8); push_t(1'b1);
        pulse_start();
        scl_cycles(9);
        idle(4);
        check("mdb_done", done_cnt - d0, 1);
        check("mdb_err", err_cnt - e0, 0);
        check("mdb_bytes", int'(bytes_sent_o), 1);
        check("mdb_busy", int'(busy_o), 0);
        check("mdb_left", exp_bits.size(), 0);

        // MDB + two data bytes with prefetch
        d0 = done_cnt; e0 = err_cnt;
        src_q.push_back({1'b0, 8'h1F});
        src_q.push_back({1'b0, 8'h00});
        src_q.push_back({1'b1, 8'hFF});
        push_bits(8'h1F, 8); push_t(1'b0);
        push_bits(8'h00, 8); push_t(1'b0);
        push_bits(8'hFF, 8); push_t(1'b1);
        pulse_start();
        scl_cycles(27);
        idle(4);
        check("multi_done", done_cnt - d0, 1);
        check("multi_err", err_cnt - e0, 0);
        check("multi_bytes", int'(bytes_sent_o), 3);
        check("multi_left", exp_bits.size(), 0);

        // Controller early termination after byte 1
        d0 = done_cnt; e0 = err_cnt; a0 = accepted;
        src_q.push_back({1'b0, 8'h11});
        src_q.push_back({1'b0, 8'h22});
        src_q.push_back({1'b1, 8'h33});
        push_bits(8'h11, 8); push_t(1'b0);
        pulse_start();
        scl_cycles(9);
        sda_i = 1'b0;
        scl_fall();
        sda_i = 1'b1;
        idle(3);
        r0 = ready_cyc;
        idle(20);
        check("cabort_err", err_cnt - e0, 1);
        check("cabort_done", done_cnt - d0, 0);
        check("cabort_busy", int'(busy_o), 0);
        check("cabort_oe", int'(sda_oe_o), 0);
        check("cabort_accepted", accepted - a0, 2);
        check("cabort_no_ready", ready_cyc - r0, 0);
        check("cabort_left", exp_bits.size(), 0);
        src_q.delete();
        idle(3);

        // Underrun: next byte withheld past TRelease negedge
        d0 = done_cnt; e0 = err_cnt;
        src_q.push_back({1'b0, 8'h5A});
        push_bits(8'h5A, 8); push_t(1'b0);
        pulse_start();
        scl_cycles(9);
        scl_fall();
        idle(3);
        check("under_err", err_cnt - e0, 1);
        check("under_done", done_cnt - d0, 0);
        check("under_oe", int'(sda_oe_o), 0);
        check("under_busy", int'(busy_o), 0);
        check("under_left", exp_bits.size(), 0);

        // abort_i while bit 4 of byte 2 is on the bus
        d0 = done_cnt; e0 = err_cnt; a0 = accepted;
        src_q.push_back({1'b0, 8'hC3});
        src_q.push_back({1'b0, 8'h3C});
        src_q.push_back({1'b1, 8'h99});
        push_bits(8'hC3, 8); push_t(1'b0);
        push_bits(8'h3C, 3);
        pulse_start();
        scl_cycles(12);
        scl_fall();
        idle(2);
        check("abort_pre_oe", int'(sda_oe_o), 1);
        check("abort_pre_bit4", int'(sda_o), 1);
        abort_i = 1'b1;
        idle(1);
        abort_i = 1'b0;
        check("abort_oe", int'(sda_oe_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_ready", int'(byte_ready_o), 0);
        r0 = ready_cyc;
        idle(20);
        check("abort_err", err_cnt - e0, 1);
        check("abort_no_ready", ready_cyc - r0, 0);
        check("abort_accepted", accepted - a0, 2);
        check("abort_bytes", int'(bytes_sent_o), 1);
        check("abort_left", exp_bits.size(), 0);
        src_q.delete();
        idle(3);

        // Fresh IBI after abort
        d0 = done_cnt; e0 = err_cnt;
        src_q.push_back({1'b1, 8'h77});
        push_bits(8'h77, 8); push_t(1'b1);
        pulse_start();
        scl_cycles(9);
        idle(4);
        check("restart_done", done_cnt - d0, 1);
        check("restart_err", err_cnt - e0, 0);
        check("restart_bytes", int'(bytes_sent_o), 1);
        check("restart_left", exp_bits.size(), 0);

        // Reset during TDrive
        d0 = done_cnt;
        src_q.push_back({1'b1, 8'h81});
        push_bits(8'h81, 8);
        pulse_start();
        scl_cycles(8);
        scl_fall();
        idle(2);
        check("tdrv_bytes", int'(bytes_sent_o), 1);
        check("tdrv_t_end", int'({sda_oe_o, sda_o}), 2);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check("rstmid_sda", int'(sda_o), 1);
        check("rstmid_oe", int'(sda_oe_o), 0);
        check("rstmid_ready", int'(byte_ready_o), 0);
        check("rstmid_busy", int'(busy_o), 0);
        check("rstmid_bytes", int'(bytes_sent_o), 0);
        check("rstmid_err_done", int'({byte_err_o, done_o}), 0);
        idle(4);
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_left", exp_bits.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
